// File: rtl/packed_burst_write_ctrl_pkg.sv
// Shared types and constants for the packed burst write controller.
package packed_burst_write_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CMD       = 2'd1,
        DATA      = 2'd2,
        FRAME_END = 2'd3
    } e_wr_state;

    // Default thermal frame geometry
    localparam int FRAME_W    = 32;
    localparam int FRAME_H    = 24;
    localparam int PIXEL_BITS = 16;

    // Bits needed for a counter that must be able to hold the value n itself
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/packed_burst_write_ctrl.sv
// Chops the packed word stream into fixed-length write bursts, one command per
// burst, ping-ponging between two frame buffers. Data moves through with zero
// latency while a burst is open; the FSM only gates the handshakes.
module packed_burst_write_ctrl
    import packed_burst_write_ctrl_pkg::*;
#(
    parameter int                p_dwidth      = 128,
    parameter int                p_awidth      = 24,
    parameter int                p_burst_len   = 8,
    parameter int                p_frame_words = FRAME_W * FRAME_H * PIXEL_BITS / 128,
    parameter logic [p_awidth-1:0] p_base0     = 'h000000,
    parameter logic [p_awidth-1:0] p_base1     = 'h001000,
    localparam int               LW            = cnt_width(p_burst_len),
    localparam int               IW            = cnt_width(p_frame_words)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic                i_valid,
    input  logic [p_dwidth-1:0] i_data,
    output logic                o_ready,
    output logic                o_cmd_valid,
    output logic [p_awidth-1:0] o_cmd_addr,
    output logic [LW-1:0]       o_cmd_len,
    input  logic                i_cmd_ready,
    output logic                o_wr_valid,
    output logic [p_dwidth-1:0] o_wr_data,
    input  logic                i_wr_ready,
    output logic                o_frame_done,
    output logic                o_frame_buf,
    output logic                o_busy
);

    e_wr_state     state;
    logic [IW-1:0] word_idx;
    logic [LW-1:0] beat_cnt;
    logic          wr_buf;
    logic          frame_buf;

    logic in_data;
    logic beat;
    logic last_beat;

    // Data path is a straight pass-through gated by the DATA state
    assign in_data    = (state == DATA);
    assign beat       = in_data & i_valid & i_wr_ready;
    assign last_beat  = (beat_cnt == LW'(p_burst_len - 1));

    assign o_ready      = in_data & i_wr_ready;
    assign o_wr_valid   = in_data & i_valid;
    assign o_wr_data    = in_data ? i_data : '0;
    assign o_cmd_valid  = (state == CMD);
    assign o_cmd_addr   = (wr_buf ? p_base1 : p_base0) + p_awidth'(word_idx);
    assign o_cmd_len    = LW'(p_burst_len - 1);
    assign o_frame_done = (state == FRAME_END);
    assign o_frame_buf  = frame_buf;
    assign o_busy       = (state != IDLE);

    // Burst sequencer: state, beat counter, frame word index and buffer select
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            word_idx  <= '0;
            beat_cnt  <= '0;
            wr_buf    <= 1'b0;
            frame_buf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_enable) state <= CMD;
                end
                CMD: begin
                    if (i_cmd_ready) begin
                        state    <= DATA;
                        beat_cnt <= '0;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + LW'(1);
                        word_idx <= word_idx + IW'(1);
                        // i_enable is only sampled at burst boundaries so a
                        // started burst always delivers its full length
                        if (last_beat) begin
                            if (word_idx == IW'(p_frame_words - 1))
                                state <= FRAME_END;
                            else
                                state <= i_enable ? CMD : IDLE;
                        end
                    end
                end
                FRAME_END: begin
                    frame_buf <= wr_buf;
                    wr_buf    <= ~wr_buf;
                    word_idx  <= '0;
                    state     <= i_enable ? CMD : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packed_burst_write_ctrl.sv
// Randomized bench with a transaction-level model: expected command addresses,
// burst lengths, data order and frame-done timing come from simple counters.
module tb_packed_burst_write_ctrl;

    localparam int DW = 128;
    localparam int AW = 24;
    localparam int BL = 8;
    localparam int FW = 96;
    localparam logic [AW-1:0] B0 = 24'h000000;
    localparam logic [AW-1:0] B1 = 24'h001000;

    logic          clk;
    logic          rst;
    logic          en;
    logic          vld;
    logic [DW-1:0] data;
    logic          o_ready;
    logic          o_cmd_valid;
    logic [AW-1:0] o_cmd_addr;
    logic [3:0]    o_cmd_len;
    logic          cmd_rdy;
    logic          o_wr_valid;
    logic [DW-1:0] o_wr_data;
    logic          wr_rdy;
    logic          o_frame_done;
    logic          o_frame_buf;
    logic          o_busy;

    packed_burst_write_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (en),
        .i_valid      (vld),
        .i_data       (data),
        .o_ready      (o_ready),
        .o_cmd_valid  (o_cmd_valid),
        .o_cmd_addr   (o_cmd_addr),
        .o_cmd_len    (o_cmd_len),
        .i_cmd_ready  (cmd_rdy),
        .o_wr_valid   (o_wr_valid),
        .o_wr_data    (o_wr_data),
        .i_wr_ready   (wr_rdy),
        .o_frame_done (o_frame_done),
        .o_frame_buf  (o_frame_buf),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stimulus knobs
    logic rst_k = 1'b1;
    logic en_k  = 1'b0;
    int   vld_pct = 0;
    int   cmd_pct = 100;
    int   wr_pct  = 100;

    // Source: a word stays presented until the controller accepts it
    logic [DW-1:0] src_q[$];
    logic          need_new = 1'b1;
    int unsigned   seq = 0;

    // Reference model state
    int   exp_idx   = 0;
    logic exp_buf   = 1'b0;
    logic exp_fbuf  = 1'b0;
    logic in_burst  = 1'b0;
    logic fd_due    = 1'b0;
    int   beats     = 0;
    int   cmd_cnt   = 0;
    int   bursts    = 0;
    int   frames    = 0;

    initial begin
        rst = 1'b1; en = 1'b0; vld = 1'b0; data = '0; cmd_rdy = 1'b0; wr_rdy = 1'b0;
    end

    // Model of the burst/frame rules, evaluated mid-cycle on stable signals
    always @(negedge clk) begin
        logic [AW-1:0] exp_addr;
        logic          was_fd;
        if (rst) begin
            if (vld && o_ready === 1'b1 && src_q.size() > 0) begin
                void'(src_q.pop_front());
                need_new = 1'b1;
            end
            exp_idx = 0; exp_buf = 1'b0; exp_fbuf = 1'b0; in_burst = 1'b0;
            fd_due = 1'b0; beats = 0; cmd_cnt = 0; bursts = 0; frames = 0;
        end else begin
            chk("frame_done", o_frame_done, fd_due);
            chk("frame_buf", o_frame_buf, exp_fbuf);
            was_fd = fd_due;
            if (was_fd || o_cmd_valid || in_burst) chk("busy", o_busy, 1'b1);
            if (fd_due) begin
                exp_fbuf = exp_buf;
                exp_buf  = ~exp_buf;
                exp_idx  = 0;
                fd_due   = 1'b0;
                frames++;
            end
            if (o_cmd_valid) begin
                exp_addr = (exp_buf ? B1 : B0) + AW'(exp_idx);
                chk("cmd_mid_burst", in_burst, 1'b0);
                chk("cmd_addr", o_cmd_addr, exp_addr);
                chk("cmd_len", o_cmd_len, 4'(BL - 1));
                chk("cmd_ready_low", o_ready, 1'b0);
                chk("cmd_wr_valid_low", o_wr_valid, 1'b0);
                if (cmd_rdy) begin
                    in_burst = 1'b1;
                    beats = 0;
                    cmd_cnt++;
                end
            end else if (in_burst) begin
                chk("wr_valid", o_wr_valid, vld);
                chk("ready", o_ready, wr_rdy);
                if (vld && wr_rdy) begin
                    chk("wr_data", o_wr_data, (src_q.size() > 0) ? src_q[0] : '0);
                    if (src_q.size() > 0) void'(src_q.pop_front());
                    need_new = 1'b1;
                    beats++;
                    exp_idx++;
                    if (beats == BL) begin
                        in_burst = 1'b0;
                        bursts++;
                        if (exp_idx == FW) fd_due = 1'b1;
                    end
                end
            end else begin
                chk("idle_wr_valid", o_wr_valid, 1'b0);
                chk("idle_ready", o_ready, 1'b0);
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        rst     = rst_k;
        en      = en_k;
        vld     = ($urandom_range(99) < vld_pct);
        cmd_rdy = ($urandom_range(99) < cmd_pct);
        wr_rdy  = ($urandom_range(99) < wr_pct);
        if (need_new) begin
            seq++;
            data = {seq, $urandom, $urandom, $urandom};
            src_q.push_back(data);
            need_new = 1'b0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            settle();
        end
    endtask

    task automatic wait_cmd(input int max_cyc);
        int k = 0;
        while (!o_cmd_valid && k < max_cyc) begin
            tick(); settle(); k++;
        end
        if (!o_cmd_valid) chk("timeout_cmd", 1'b0, 1'b1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, o_busy, 1'b0);
        chk({tag, "_cmd_valid"}, o_cmd_valid, 1'b0);
        chk({tag, "_wr_valid"}, o_wr_valid, 1'b0);
        chk({tag, "_ready"}, o_ready, 1'b0);
        chk({tag, "_frame_done"}, o_frame_done, 1'b0);
    endtask

    initial begin
        int k;
        logic [AW-1:0] a0;

        // Reset state
        rst_k = 1'b1; en_k = 1'b0;
        step(3);
        rst_k = 1'b0;
        step(2);
        chk_quiet("reset");
        chk("reset_frame_buf", o_frame_buf, 1'b0);

        // Full rate: two complete frames
        en_k = 1'b1; vld_pct = 100; cmd_pct = 100; wr_pct = 100;
        step(240);
        chk("frames_done", frames, 2);
        chk("frame_buf_after_two", o_frame_buf, 1'b1);

        // Command stall for five cycles
        cmd_pct = 0;
        wait_cmd(40);
        a0 = o_cmd_addr;
        for (int i = 0; i < 5; i++) begin
            tick(); settle();
            chk("stall_cmd_valid", o_cmd_valid, 1'b1);
            chk("stall_addr", o_cmd_addr, a0);
            chk("stall_ready", o_ready, 1'b0);
        end
        cmd_pct = 100;

        // Random backpressure and gaps
        vld_pct = 70; cmd_pct = 60; wr_pct = 50;
        step(900);

        // Drop enable at beat 3 of burst 2
        rst_k = 1'b1; step(2); rst_k = 1'b0;
        en_k = 1'b1; vld_pct = 100; cmd_pct = 100; wr_pct = 100;
        k = 0;
        while (!(cmd_cnt == 2 && in_burst && beats == 3) && k < 60) begin
            tick(); settle(); k++;
        end
        if (k >= 60) chk("timeout_beat3", 1'b0, 1'b1);
        en_k = 1'b0;
        k = 0;
        while (o_busy && k < 30) begin
            tick(); settle(); k++;
        end
        chk("drop_idle", o_busy, 1'b0);
        chk("drop_bursts", bursts, 2);
        step(3);
        chk("drop_still_idle", o_busy, 1'b0);
        en_k = 1'b1;
        wait_cmd(10);
        chk("resume_addr", o_cmd_addr, 24'h000010);

        // Reset at beat 4 of a burst
        k = 0;
        while (!(in_burst && beats == 4) && k < 40) begin
            tick(); settle(); k++;
        end
        if (k >= 40) chk("timeout_beat4", 1'b0, 1'b1);
        rst_k = 1'b1; tick(); settle();
        rst_k = 1'b0; tick(); settle();
        chk_quiet("mid_reset");
        wait_cmd(10);
        chk("post_reset_addr", o_cmd_addr, 24'h000000);
        vld_pct = 80; cmd_pct = 70; wr_pct = 70;
        step(200);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
